// File: rtl/sdram_frame_reader.sv
// rtl/sdram_frame_reader.sv - SDRAM read-back engine serializing pixel words to a byte stream
// Optional feature macro: READER_ALPHA_EN (emit the low padding byte as a fourth byte per word)
module sdram_frame_reader #(
  parameter int ADDR_W     = 23,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] word_count,
  output logic [ADDR_W-1:0] addr,
  output logic              rw,
  output logic [31:0]       data_in,
  input  logic [31:0]       data_out,
  input  logic              busy,
  output logic              in_valid,
  input  logic              out_valid,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              active,
  output logic              done,
  output logic              error
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_LIM = (CNT_W+1)'(FIFO_DEPTH);

`ifdef READER_ALPHA_EN
  localparam logic [1:0] LAST_BYTE = 2'd3;
`else
  localparam logic [1:0] LAST_BYTE = 2'd2;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] remaining;
  logic [CNT_W-1:0]  outstanding;
  logic [CNT_W-1:0]  fifo_count;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [31:0]       fifo_mem [FIFO_DEPTH];
  logic [31:0]       shift_word;
  logic [1:0]        byte_idx;

  logic credit_ok;
  logic issue;
  logic push;
  logic pop;
  logic tx_fire;
  logic ser_free;
  logic drain_done;

  // Request issue, return acceptance and serializer hand-off conditions
  always_comb begin
    credit_ok  = ({1'b0, outstanding} + {1'b0, fifo_count}) < DEPTH_LIM;
    issue      = (state == S_RUN) && (remaining != '0) && !busy && credit_ok;
    push       = out_valid && (outstanding != '0);
    tx_fire    = tx_valid && tx_ready;
    // Serializer can take a new word now: either empty, or its last byte leaves this cycle
    ser_free   = !tx_valid || (tx_fire && (byte_idx == LAST_BYTE));
    pop        = ser_free && (fifo_count != '0);
    drain_done = (outstanding == '0) && (fifo_count == '0) && ser_free;
  end

  // Controller-facing request outputs; address is forced to zero when no request
  always_comb begin
    in_valid = issue;
    addr     = issue ? rd_addr : '0;
    rw       = 1'b0;
    data_in  = 32'd0;
    active   = (state != S_IDLE);
    tx_data  = shift_word[31:24];
  end

  // Transfer sequencing: address/count tracking and the completion pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      rd_addr   <= '0;
      remaining <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (word_count != '0) begin
              rd_addr   <= start_addr;
              remaining <= word_count;
              state     <= S_RUN;
            end else begin
              done <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (issue) begin
            rd_addr   <= rd_addr + ADDR_W'(1);
            remaining <= remaining - ADDR_W'(1);
            if (remaining == ADDR_W'(1)) begin
              state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          // Finish in the cycle the last byte is taken so done lands right after it
          if (drain_done) begin
            done  <= 1'b1;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Credit accounting: reads in flight plus words buffered never exceed FIFO_DEPTH
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      outstanding <= '0;
      fifo_count  <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      error       <= 1'b0;
    end else begin
      case ({issue, push})
        2'b10:   outstanding <= outstanding + CNT_W'(1);
        2'b01:   outstanding <= outstanding - CNT_W'(1);
        default: outstanding <= outstanding;
      endcase
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      // Data nobody asked for is dropped and flagged until the next reset
      if (out_valid && (outstanding == '0)) begin
        error <= 1'b1;
      end
    end
  end

  // Return-word storage; contents need no reset since fifo_count gates every read
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= data_out;
    end
  end

  // Byte serializer: most significant byte first, holds until the sink takes it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_word <= '0;
      byte_idx   <= '0;
      tx_valid   <= 1'b0;
    end else begin
      if (pop) begin
        shift_word <= fifo_mem[rd_ptr];
        byte_idx   <= 2'd0;
        tx_valid   <= 1'b1;
      end else if (tx_fire) begin
        if (byte_idx == LAST_BYTE) begin
          tx_valid <= 1'b0;
        end else begin
          shift_word <= {shift_word[23:0], 8'h00};
          byte_idx   <= byte_idx + 2'd1;
        end
      end
    end
  end

endmodule
